// File: rtl/itcm_loader_pkg.sv
// Shared types and constants for the ITCM boot-image loader.
package itcm_loader_pkg;

    localparam int LANES            = 8;
    localparam int E203_ITCM_RAM_AW = 13;
    localparam int ITCM_DEPTH       = 1 << E203_ITCM_RAM_AW;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        FIN
    } state_e;

endpackage

// File: rtl/itcm_byte_packer.sv
// Little-endian byte packer: lane pointer, word buffer and filled-lane mask.
module itcm_byte_packer
    import itcm_loader_pkg::*;
#(
    parameter int N_LANES = LANES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   acc,
    input  logic [7:0]             data,
    output logic [N_LANES*8-1:0]   word,
    output logic [N_LANES-1:0]     mask,
    output logic                   lane_full
);

    localparam int LW = $clog2(N_LANES);

    logic [LW-1:0] lane;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            lane <= '0;
            word <= '0;
            mask <= '0;
        end else if (acc) begin
            word[lane*8 +: 8] <= data;
            mask[lane]        <= 1'b1;
            lane              <= lane + 1'b1;
        end
    end

    assign lane_full = (lane == LW'(N_LANES - 1));

endmodule

// File: rtl/itcm_image_loader.sv
// Streams a byte-wide boot image into consecutive 64-bit ITCM words.
module itcm_image_loader
    import itcm_loader_pkg::*;
#(
    parameter int RAM_AW    = E203_ITCM_RAM_AW,
    parameter int RAM_DW    = 64,
    parameter int RAM_MW    = RAM_DW / 8,
    parameter int BASE_WORD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_vld,
    output logic              byte_rdy,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_MW-1:0] ram_wem,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_din,
    output logic              busy,
    output logic              done,
    output logic              err_ovf,
    output logic [RAM_AW:0]   word_cnt
);

    localparam logic [RAM_AW:0]   DEPTH     = {1'b1, {RAM_AW{1'b0}}};
    localparam logic [RAM_AW:0]   BASE_CNT  = (RAM_AW + 1)'(BASE_WORD);
    localparam logic [RAM_AW-1:0] BASE_ADDR = RAM_AW'(BASE_WORD);

    state_e              state;
    logic [RAM_AW-1:0]   addr;
    logic                last_pend;
    logic [RAM_DW-1:0]   pk_word;
    logic [RAM_MW-1:0]   pk_mask;
    logic                pk_full;
    logic                accept;
    logic                start_go;
    logic                at_limit;
    logic [RAM_AW:0]     cnt_inc;

    assign accept   = byte_vld & byte_rdy;
    assign start_go = start & ((state == IDLE) | (state == FIN));
    assign cnt_inc  = word_cnt + {{RAM_AW{1'b0}}, 1'b1};
    // Address space is exhausted once the next word would land past the last ITCM row.
    assign at_limit = ((word_cnt + BASE_CNT) == DEPTH);

    itcm_byte_packer #(
        .N_LANES (RAM_MW)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       ((state == WRITE) | start_go),
        .acc       (accept),
        .data      (byte_data),
        .word      (pk_word),
        .mask      (pk_mask),
        .lane_full (pk_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            word_cnt  <= '0;
            last_pend <= 1'b0;
            byte_rdy  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_ovf   <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state     <= FILL;
                        addr      <= BASE_ADDR;
                        word_cnt  <= '0;
                        last_pend <= 1'b0;
                        done      <= 1'b0;
                        err_ovf   <= 1'b0;
                        busy      <= 1'b1;
                        byte_rdy  <= (BASE_CNT != DEPTH);
                    end
                end
                FILL: begin
                    if (at_limit && byte_vld) begin
                        state    <= FIN;
                        err_ovf  <= 1'b1;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        byte_rdy <= 1'b0;
                    end else if (accept && (pk_full || byte_last)) begin
                        state     <= WRITE;
                        byte_rdy  <= 1'b0;
                        ram_cs    <= 1'b1;
                        ram_we    <= 1'b1;
                        last_pend <= byte_last;
                    end
                end
                WRITE: begin
                    ram_cs   <= 1'b0;
                    ram_we   <= 1'b0;
                    word_cnt <= cnt_inc;
                    addr     <= addr + 1'b1;
                    if (last_pend) begin
                        state <= FIN;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state    <= FILL;
                        byte_rdy <= ((cnt_inc + BASE_CNT) != DEPTH);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ram_din  = ram_cs ? pk_word : '0;
    assign ram_wem  = ram_cs ? pk_mask : '0;
    assign ram_addr = ram_cs ? addr    : '0;

endmodule

// File: tb/tb_itcm_image_loader.sv
// Directed bench for itcm_image_loader with a shallow ITCM so overflow is reachable.
module tb_itcm_image_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          byte_vld;
    logic          byte_rdy;
    logic [7:0]    byte_data;
    logic          byte_last;
    logic          ram_cs;
    logic          ram_we;
    logic [7:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_din;
    logic          busy;
    logic          done;
    logic          err_ovf;
    logic [AW:0]   word_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    int rdy_bad  = 0;
    int we_bad   = 0;
    bit chk_rdy  = 1'b0;

    logic [63:0] wr_addr[$];
    logic [63:0] wr_din[$];
    logic [63:0] wr_wem[$];

    itcm_image_loader #(
        .RAM_AW    (AW),
        .RAM_DW    (64),
        .RAM_MW    (8),
        .BASE_WORD (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .byte_vld  (byte_vld),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .byte_last (byte_last),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wem   (ram_wem),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf),
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ram_cs) begin
            wr_addr.push_back(64'(ram_addr));
            wr_din.push_back(ram_din);
            wr_wem.push_back(64'(ram_wem));
        end
        if (ram_we != ram_cs) we_bad++;
        if (chk_rdy && busy && (byte_rdy == ram_cs)) rdy_bad++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] wr_at(input int kind, input int i);
        if (i >= wr_din.size()) return 'x;
        case (kind)
            0: return wr_addr[i];
            1: return wr_din[i];
            default: return wr_wem[i];
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycles(1);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_din.delete();
        wr_wem.delete();
    endtask

    // Offers n bytes (first, first+1, ...); stops early if the loader reports done.
    task automatic stream(input int n, input logic [7:0] first, input bit with_last,
                          input bit gaps, output int accepted);
        int idx = 0;
        int cyc = 0;
        while (idx < n && cyc < 400) begin
            byte_vld  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data = byte_vld ? first + 8'(idx) : 8'hEE;
            byte_last = byte_vld && with_last && (idx == n - 1);
            @(negedge clk);
            if (byte_vld && byte_rdy) idx++;
            if (done) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done && idx < n) chk_eq("stream_timeout", 64'(idx), 64'(n));
        byte_vld  = 1'b0;
        byte_last = 1'b0;
        byte_data = 8'h00;
        accepted  = idx;
        if (done) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc;
        rst_n     = 1'b0;
        start     = 1'b0;
        byte_vld  = 1'b0;
        byte_data = 8'h00;
        byte_last = 1'b0;
        cycles(3);
        rst_n = 1'b1;

        chk_eq("rst_rdy",  64'(byte_rdy), 64'd0);
        chk_eq("rst_cs",   64'(ram_cs),   64'd0);
        chk_eq("rst_busy", 64'(busy),     64'd0);
        chk_eq("rst_done", 64'(done),     64'd0);
        chk_eq("rst_cnt",  64'(word_cnt), 64'd0);

        // Two full words
        clear_log();
        pulse_start();
        chk_eq("fw_busy", 64'(busy), 64'd1);
        stream(16, 8'h00, 1'b1, 1'b0, acc);
        cycles(3);
        chk_eq("fw_nwr",   64'(wr_din.size()), 64'd2);
        chk_eq("fw_addr0", wr_at(0, 0), 64'd0);
        chk_eq("fw_din0",  wr_at(1, 0), 64'h0706050403020100);
        chk_eq("fw_wem0",  wr_at(2, 0), 64'hFF);
        chk_eq("fw_addr1", wr_at(0, 1), 64'd1);
        chk_eq("fw_din1",  wr_at(1, 1), 64'h0F0E0D0C0B0A0908);
        chk_eq("fw_wem1",  wr_at(2, 1), 64'hFF);
        chk_eq("fw_done",  64'(done),     64'd1);
        chk_eq("fw_busy0", 64'(busy),     64'd0);
        chk_eq("fw_cnt",   64'(word_cnt), 64'd2);

        // Partial tail word
        clear_log();
        pulse_start();
        stream(11, 8'hA0, 1'b1, 1'b0, acc);
        cycles(3);
        chk_eq("pt_nwr",   64'(wr_din.size()), 64'd2);
        chk_eq("pt_din0",  wr_at(1, 0), 64'hA7A6A5A4A3A2A1A0);
        chk_eq("pt_addr1", wr_at(0, 1), 64'd1);
        chk_eq("pt_din1",  wr_at(1, 1), 64'h0000000000AAA9A8);
        chk_eq("pt_wem1",  wr_at(2, 1), 64'h07);
        chk_eq("pt_cnt",   64'(word_cnt), 64'd2);

        // Valid gaps with garbage data while idle
        clear_log();
        rdy_bad = 0;
        chk_rdy = 1'b1;
        pulse_start();
        stream(8, 8'h30, 1'b1, 1'b1, acc);
        cycles(3);
        chk_rdy = 1'b0;
        chk_eq("bp_nwr",  64'(wr_din.size()), 64'd1);
        chk_eq("bp_din",  wr_at(1, 0), 64'h3736353433323130);
        chk_eq("bp_wem",  wr_at(2, 0), 64'hFF);
        chk_eq("bp_rdy",  64'(rdy_bad), 64'd0);
        chk_eq("bp_done", 64'(done), 64'd1);

        // Overflow of a 4-word ITCM
        clear_log();
        pulse_start();
        stream(40, 8'h00, 1'b0, 1'b0, acc);
        cycles(6);
        chk_eq("ov_acc",   64'(acc), 64'd32);
        chk_eq("ov_nwr",   64'(wr_din.size()), 64'd4);
        chk_eq("ov_addr0", wr_at(0, 0), 64'd0);
        chk_eq("ov_addr3", wr_at(0, 3), 64'd3);
        chk_eq("ov_din3",  wr_at(1, 3), 64'h1F1E1D1C1B1A1918);
        chk_eq("ov_err",   64'(err_ovf),  64'd1);
        chk_eq("ov_done",  64'(done),     64'd1);
        chk_eq("ov_busy",  64'(busy),     64'd0);
        chk_eq("ov_rdy",   64'(byte_rdy), 64'd0);
        chk_eq("ov_cnt",   64'(word_cnt), 64'd4);

        // Restart from FIN clears the sticky flags
        clear_log();
        pulse_start();
        chk_eq("rs_done", 64'(done),     64'd0);
        chk_eq("rs_err",  64'(err_ovf),  64'd0);
        chk_eq("rs_busy", 64'(busy),     64'd1);
        chk_eq("rs_rdy",  64'(byte_rdy), 64'd1);
        chk_eq("rs_cnt",  64'(word_cnt), 64'd0);
        stream(8, 8'h70, 1'b1, 1'b0, acc);
        cycles(3);
        chk_eq("rs_nwr",  64'(wr_din.size()), 64'd1);
        chk_eq("rs_addr", wr_at(0, 0), 64'd0);
        chk_eq("rs_din",  wr_at(1, 0), 64'h7776757473727170);

        // start while busy must not disturb the load
        clear_log();
        pulse_start();
        stream(3, 8'h60, 1'b0, 1'b0, acc);
        pulse_start();
        stream(5, 8'h63, 1'b1, 1'b0, acc);
        cycles(3);
        chk_eq("sb_nwr",  64'(wr_din.size()), 64'd1);
        chk_eq("sb_din",  wr_at(1, 0), 64'h6766656463626160);
        chk_eq("sb_cnt",  64'(word_cnt), 64'd1);

        // Reset in the middle of a word
        clear_log();
        pulse_start();
        stream(5, 8'h40, 1'b0, 1'b0, acc);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        chk_eq("mr_rdy",  64'(byte_rdy), 64'd0);
        chk_eq("mr_cs",   64'(ram_cs),   64'd0);
        chk_eq("mr_we",   64'(ram_we),   64'd0);
        chk_eq("mr_wem",  64'(ram_wem),  64'd0);
        chk_eq("mr_addr", 64'(ram_addr), 64'd0);
        chk_eq("mr_din",  ram_din,       64'd0);
        chk_eq("mr_busy", 64'(busy),     64'd0);
        chk_eq("mr_done", 64'(done),     64'd0);
        chk_eq("mr_err",  64'(err_ovf),  64'd0);
        chk_eq("mr_cnt",  64'(word_cnt), 64'd0);
        chk_eq("mr_nwr",  64'(wr_din.size()), 64'd0);
        pulse_start();
        stream(8, 8'h50, 1'b1, 1'b0, acc);
        cycles(3);
        chk_eq("mr_nwr2", 64'(wr_din.size()), 64'd1);
        chk_eq("mr_addr2", wr_at(0, 0), 64'd0);
        chk_eq("mr_din2", wr_at(1, 0), 64'h5756555453525150);
        chk_eq("mr_wem2", wr_at(2, 0), 64'hFF);

        chk_eq("we_eq_cs", 64'(we_bad), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/itcm_image_loader.md
Name: itcm_image_loader

Overview:
- Synthesizable boot-image loader that sits directly upstream of the ITCM SRAM's 64-bit write port.
- Accepts a byte stream over a valid/ready handshake, packs the bytes little-endian into 64-bit words and writes them to consecutive ITCM word addresses.
- Replaces simulation-only backdoor preload; lets rv32ui test images be streamed in from a host UART/JTAG bridge before core reset is released.

Parameters:
- RAM_AW, 13, ITCM word-address width (8192 x 64-bit = 64 KB).
- RAM_DW, 64, ITCM data width; fixed at 64.
- RAM_MW, 8, byte lanes per word (RAM_DW/8).
- BASE_WORD, 0, first word address written after start.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a new load
- byte_vld  in  1  input byte valid
- byte_rdy  out  1  loader can accept a byte
- byte_data  in  8  image byte
- byte_last  in  1  qualifies final byte of image
- ram_cs  out  1  ITCM chip select
- ram_we  out  1  ITCM write enable
- ram_wem  out  8  byte write mask, bit k = lane k
- ram_addr  out  RAM_AW  word address
- ram_din  out  64  write data
- busy  out  1  load in progress
- done  out  1  sticky; image fully written
- err_ovf  out  1  sticky; image exceeded ITCM depth
- word_cnt  out  RAM_AW+1  words written in current load

Behaviour:
- Reset (rst_n=0 at clk edge), regardless of state: state=IDLE; all outputs 0; pack buffer, lane pointer and address cleared. Reset mid-load abandons the load; no partial word is written.
- FSM states: IDLE, FILL, WRITE, FIN.
- IDLE: byte_rdy=0. start goes to FILL with addr=BASE_WORD, lane=0, word_cnt=0, done=0, err_ovf=0.
- FILL: byte_rdy=1; busy=1.
  - Each accepted byte (vld&rdy) is stored in lane `lane`; its wem bit is set; lane increments.
  - Goes to WRITE when lane reaches 7 on acceptance, or on an accepted byte_last.
- WRITE: exactly one cycle; byte_rdy=0; ram_cs=ram_we=1; ram_addr=addr; ram_din=packed buffer (unfilled lanes 0); ram_wem=filled-lane mask.
  - word_cnt and addr increment; lane and mask clear.
  - Goes to FIN if the word held last, otherwise to FILL.
- Timing: a word is written on the cycle after its 8th (or last) byte is accepted. Sustained rate is 9 cycles per full word.
- Overflow: in FILL, if addr wrapped to 2^RAM_AW (word_cnt+BASE_WORD == 2^RAM_AW) and byte_vld=1, set err_ovf and go to FIN. That byte is not accepted; addr never wraps, so ITCM is never overwritten.
- FIN: busy=0; done=1 (sticky, also set with err_ovf); byte_rdy=0. start goes to FILL with fresh init.
- start while busy is ignored.
- byte_last with no pending bytes cannot occur, since byte_last qualifies a byte.
- ram_cs is 0 in every state except WRITE.
- byte_data is captured only on handshake; byte_vld may drop mid-word, and FILL waits indefinitely.

Decomposition:
- Shared package itcm_loader_pkg:
  - state enum (IDLE/FILL/WRITE/FIN)
  - LANES=8
  - ITCM depth constant derived from E203_ITCM_RAM_AW
- One natural sub-module, itcm_byte_packer: lane pointer, 64-bit buffer, wem mask accumulate/clear.
- Top holds the FSM, address counter and flags.

Test Plan:
- Full words: start, then 16 bytes 0x00..0x0F with last on 0x0F -> two writes: addr 0 din 0x0706050403020100 wem 0xFF; addr 1 din 0x0F0E0D0C0B0A0908 wem 0xFF; done=1, word_cnt=2.
- Partial tail: 11 bytes 0xA0..0xAA, last on 0xAA -> second write at addr 1, din 0x0000000000AAA9A8, wem 0x07.
- Backpressure/gaps: byte_vld toggled randomly while streaming 8 bytes -> exactly one write, byte_rdy low only in the WRITE cycle, data unchanged.
- Overflow: RAM_AW=2, stream 40 bytes with no last -> 4 writes (addr 0..3), err_ovf=1, done=1, byte 33 never accepted, no fifth ram_cs.
- Reset mid-load: rst_n low after 5 bytes -> no write issued, all outputs 0 next cycle; new start plus 8 bytes writes at addr BASE_WORD.
- start during busy ignored; start in FIN clears done/err_ovf and restarts at BASE_WORD.
